// File: rtl/pu_sequencer_if.sv
// Control bundle between the PU sequencer and the datapath it steers
// (PU, weight memory, ping-pong activation buffers).
interface pu_sequencer_if #(
    parameter int IDX_W = 2,
    parameter int LYR_W = 1
);
    logic                   start;
    logic                   ldIn;
    logic                   ldM;
    logic                   ldRes;
    logic                   wrOut;
    logic [LYR_W+IDX_W-1:0] wAddr;
    logic [IDX_W-1:0]       outIdx;
    logic [LYR_W-1:0]       layerIdx;
    logic                   rdBuf;
    logic                   busy;
    logic                   done;

    modport master (
        input  start,
        output ldIn, ldM, ldRes, wrOut, wAddr, outIdx, layerIdx, rdBuf, busy, done
    );

    modport slave (
        output start,
        input  ldIn, ldM, ldRes, wrOut, wAddr, outIdx, layerIdx, rdBuf, busy, done
    );
endinterface

// File: rtl/pu_sequencer.sv
// Moore sequencer stepping the PU through NUM_LAYERS dense layers of NUM_OUT
// neurons: load inputs once per layer, then multiply / reduce / write per neuron.
module pu_sequencer #(
    parameter int NUM_OUT    = 4,
    parameter int NUM_LAYERS = 2,
    parameter int IDX_W      = 2,
    parameter int LYR_W      = 1
) (
    input  logic           clk,
    input  logic           rst,
    pu_sequencer_if.master bus
);

    // Terminal counts are parameter-derived so non-power-of-two sizes never wrap.
    localparam logic [IDX_W-1:0] OUT_LAST = IDX_W'(NUM_OUT - 1);
    localparam logic [LYR_W-1:0] LYR_LAST = LYR_W'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_IN,
        MUL,
        ADD,
        WRITE,
        DONE
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] out_q;
    logic [LYR_W-1:0] lyr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            lyr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= LOAD_IN;
                        out_q   <= '0;
                        lyr_q   <= '0;
                    end
                end
                LOAD_IN: state_q <= MUL;
                MUL:     state_q <= ADD;
                ADD:     state_q <= WRITE;
                WRITE: begin
                    if (out_q < OUT_LAST) begin
                        out_q   <= out_q + IDX_W'(1);
                        state_q <= MUL;
                    end else if (lyr_q < LYR_LAST) begin
                        out_q   <= '0;
                        lyr_q   <= lyr_q + LYR_W'(1);
                        state_q <= LOAD_IN;
                    end else begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Every output is a pure decode of state/counters, so start never reaches an output.
    assign bus.ldIn     = (state_q == LOAD_IN);
    assign bus.ldM      = (state_q == MUL);
    assign bus.ldRes    = (state_q == ADD);
    assign bus.wrOut    = (state_q == WRITE);
    assign bus.done     = (state_q == DONE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.outIdx   = out_q;
    assign bus.layerIdx = lyr_q;
    assign bus.wAddr    = {lyr_q, out_q};
    assign bus.rdBuf    = lyr_q[0];

endmodule
